// File: rtl/skip_pkg.sv
// Shared constants and FSM encoding for the skip ring consumer.
package skip_pkg;

    localparam int unsigned SKIP_LEN = 16;
    localparam logic [SKIP_LEN-1:0] SKIP_MASK = 16'b0011010001000101;

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } skip_state_e;

endpackage

// File: rtl/skip_edge_sync.sv
// Two-flop synchronisers for SCLK and B0 plus an enable-gated rising-edge detect on SCLK.
module skip_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic sclk_i,
    input  logic b0_i,
    output logic rise_o,
    output logic b0_s_o
);

    logic sclk_s1_q, sclk_s2_q, sclk_d_q;
    logic b0_s1_q, b0_s2_q;

    // Sync flops run regardless of en_i so a re-enable never sees a stale edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_d_q  <= 1'b0;
            b0_s1_q   <= 1'b0;
            b0_s2_q   <= 1'b0;
        end else begin
            sclk_s1_q <= sclk_i;
            sclk_s2_q <= sclk_s1_q;
            sclk_d_q  <= sclk_s2_q;
            b0_s1_q   <= b0_i;
            b0_s2_q   <= b0_s1_q;
        end
    end

    assign rise_o = sclk_s2_q & ~sclk_d_q & en_i;
    assign b0_s_o = b0_s2_q;

endmodule

// File: rtl/skip_monitor.sv
// Deserialises ring bit 0 on each skipped-clock edge, aligns to the expected frame,
// reports lock and counts bad frames seen while locked.
module skip_monitor
    import skip_pkg::*;
#(
    parameter int unsigned     LEN      = SKIP_LEN,
    parameter logic [LEN-1:0]  MASK     = SKIP_MASK,
    parameter int unsigned     LOSS_THR = 3,
    parameter int unsigned     ERRW     = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            sclk_i,
    input  logic            b0_i,
    output logic            strobe_o,
    output logic [LEN-1:0]  word_o,
    output logic            word_valid_o,
    output logic            lock_o,
    output logic [ERRW-1:0] err_cnt_o
);

    localparam int unsigned PW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned MW = $clog2(LOSS_THR + 1);
    localparam logic [PW-1:0] PhaseLast = PW'(LEN - 1);
    localparam logic [MW-1:0] MissThr   = MW'(LOSS_THR);

    logic rise, b0_s;

    skip_edge_sync u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .sclk_i (sclk_i),
        .b0_i   (b0_i),
        .rise_o (rise),
        .b0_s_o (b0_s)
    );

    skip_state_e     state_q, state_d;
    logic [LEN-1:0]  window_q, window_d, nxt_win;
    logic [PW-1:0]   phase_q, phase_d;
    logic [MW-1:0]   miss_q, miss_d, miss_inc;
    logic [LEN-1:0]  word_q, word_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            strobe_q, strobe_d;
    logic            wv_q, wv_d;

    always_comb begin
        nxt_win  = {window_q[LEN-2:0], b0_s};
        miss_inc = miss_q + 1'b1;
        state_d  = state_q;
        window_d = window_q;
        phase_d  = phase_q;
        miss_d   = miss_q;
        word_d   = word_q;
        err_d    = err_q;
        strobe_d = rise;
        wv_d     = 1'b0;

        if (rise) begin
            window_d = nxt_win;
            case (state_q)
                S_SEARCH: begin
                    if (nxt_win == MASK) begin
                        state_d = S_LOCKED;
                        phase_d = '0;
                        miss_d  = '0;
                        word_d  = nxt_win;
                        wv_d    = 1'b1;
                    end
                end
                S_LOCKED: begin
                    phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
                    if (phase_q == PhaseLast) begin
                        word_d = nxt_win;
                        wv_d   = 1'b1;
                        if (nxt_win == MASK) begin
                            miss_d = '0;
                        end else begin
                            if (err_q != {ERRW{1'b1}}) begin
                                err_d = err_q + 1'b1;
                            end
                            if (miss_inc == MissThr) begin
                                state_d = S_SEARCH;
                                phase_d = '0;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_inc;
                            end
                        end
                    end
                end
                default: state_d = S_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_SEARCH;
            window_q <= '0;
            phase_q  <= '0;
            miss_q   <= '0;
            word_q   <= '0;
            err_q    <= '0;
            strobe_q <= 1'b0;
            wv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            phase_q  <= phase_d;
            miss_q   <= miss_d;
            word_q   <= word_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            wv_q     <= wv_d;
        end
    end

    assign strobe_o     = strobe_q;
    assign word_o       = word_q;
    assign word_valid_o = wv_q;
    assign lock_o       = (state_q == S_LOCKED);
    assign err_cnt_o    = err_q;

endmodule

// File: tb/tb_skip_monitor.sv
// Directed bench for skip_monitor: frame table plus hand sequences for latency, enable,
// mid-frame reset and error-counter saturation.
module tb_skip_monitor;

    localparam logic [15:0] M = 16'h3445;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        en2 = 1'b0;
    logic        sclk = 1'b0;
    logic        b0 = 1'b0;

    logic        strobe, wv, lock;
    logic [15:0] word;
    logic [7:0]  err;

    logic        strobe2, wv2, lock2;
    logic [15:0] word2;
    logic [1:0]  err2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_strobe = 0;
    int n_wv     = 0;
    logic [15:0] last_word = '0;

    always #5 clk = ~clk;

    skip_monitor u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .sclk_i       (sclk),
        .b0_i         (b0),
        .strobe_o     (strobe),
        .word_o       (word),
        .word_valid_o (wv),
        .lock_o       (lock),
        .err_cnt_o    (err)
    );

    skip_monitor #(
        .LOSS_THR (8),
        .ERRW     (2)
    ) u_dut_sat (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en2),
        .sclk_i       (sclk),
        .b0_i         (b0),
        .strobe_o     (strobe2),
        .word_o       (word2),
        .word_valid_o (wv2),
        .lock_o       (lock2),
        .err_cnt_o    (err2)
    );

    always @(negedge clk) begin
        if (strobe) n_strobe <= n_strobe + 1;
        if (wv) begin
            n_wv      <= n_wv + 1;
            last_word <= word;
        end
    end

    typedef struct {
        logic [15:0] frame;
        logic        exp_lock;
        logic [7:0]  exp_err;
        logic [15:0] exp_word;
    } row_t;

    row_t rows [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One SCLK pulse, 4 CLK high / 4 CLK low; entered and left at a negedge.
    task automatic send_bit(input logic b);
        b0   = b;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(f[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s0, w0, lat;
        rows[0] = '{M,            1'b1, 8'd0, M};
        rows[1] = '{M,            1'b1, 8'd0, M};
        rows[2] = '{M,            1'b1, 8'd0, M};
        rows[3] = '{M,            1'b1, 8'd0, M};
        rows[4] = '{M ^ 16'h0001, 1'b1, 8'd1, 16'h3444};
        rows[5] = '{M ^ 16'h0100, 1'b1, 8'd2, 16'h3545};
        rows[6] = '{M,            1'b1, 8'd2, M};
        rows[7] = '{M ^ 16'h8000, 1'b1, 8'd3, 16'hB445};
        rows[8] = '{M ^ 16'h0010, 1'b1, 8'd4, 16'h3455};
        rows[9] = '{M ^ 16'h0002, 1'b0, 8'd5, 16'h3447};

        // Reset held 3 CLK with SCLK toggling
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sclk = ~sclk;
            @(negedge clk);
        end
        check("reset_strobe", {31'd0, strobe}, 32'd0);
        check("reset_word", {16'd0, word}, 32'd0);
        check("reset_wv", {31'd0, wv}, 32'd0);
        check("reset_lock", {31'd0, lock}, 32'd0);
        check("reset_err", {24'd0, err}, 32'd0);
        sclk = 1'b0;
        rst  = 1'b0;
        repeat (3) @(negedge clk);

        // STROBE latency: first sample where it is high must be the 3rd CLK
        b0   = 1'b0;
        sclk = 1'b1;
        lat  = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (strobe && lat == 0) lat = i;
        end
        check("strobe_latency", lat, 32'd3);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        do_reset();

        for (int r = 0; r < 10; r++) begin
            s0 = n_strobe;
            w0 = n_wv;
            send_bits(rows[r].frame, 15, 0);
            check($sformatf("row%0d_strobes", r), n_strobe - s0, 32'd16);
            check($sformatf("row%0d_wv", r), n_wv - w0, 32'd1);
            check($sformatf("row%0d_word", r), {16'd0, last_word}, {16'd0, rows[r].exp_word});
            check($sformatf("row%0d_lock", r), {31'd0, lock}, {31'd0, rows[r].exp_lock});
            check($sformatf("row%0d_err", r), {24'd0, err}, {24'd0, rows[r].exp_err});
        end

        // Enable freeze: 5 lost edges mid-frame
        do_reset();
        send_bits(M, 15, 0);
        check("en_lock", {31'd0, lock}, 32'd1);
        w0 = n_wv;
        send_bits(M, 15, 9);
        en = 1'b0;
        s0 = n_strobe;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("en_off_strobes", n_strobe - s0, 32'd0);
        en = 1'b1;
        send_bits(M, 8, 1);
        check("en_no_early_wv", n_wv - w0, 32'd0);
        send_bit(M[0]);
        check("en_frame_wv", n_wv - w0, 32'd1);
        check("en_frame_word", {16'd0, last_word}, {16'd0, M});
        check("en_err", {24'd0, err}, 32'd0);

        // Mid-frame reset clears ERR_CNT; relock needs a full match
        send_bits(M ^ 16'h0040, 15, 0);
        check("pre_rst_err", {24'd0, err}, 32'd1);
        send_bits(M, 15, 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_lock", {31'd0, lock}, 32'd0);
        check("midrst_err", {24'd0, err}, 32'd0);
        check("midrst_word", {16'd0, word}, 32'd0);
        repeat (3) @(negedge clk);
        send_bits(M, 15, 1);
        check("relock_15", {31'd0, lock}, 32'd0);
        send_bit(M[0]);
        check("relock_16", {31'd0, lock}, 32'd1);
        check("relock_word", {16'd0, word}, {16'd0, M});

        // Saturation on the ERRW=2 / LOSS_THR=8 instance
        en2 = 1'b1;
        send_bits(M, 15, 0);
        check("sat_lock", {31'd0, lock2}, 32'd1);
        for (int f = 1; f <= 6; f++) begin
            send_bits(M ^ 16'h0004, 15, 0);
            check($sformatf("sat_err%0d", f), {30'd0, err2}, (f < 3) ? f : 3);
            check($sformatf("sat_lock%0d", f), {31'd0, lock2}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
